fcb_config_loader: RTL
======================

FCB_CONFIG_LOADER -- requirements
Module: fcb_config_loader

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 1: number of parallel ccff configuration chains (1..32).
REQ-002 SHALL have parameter CHAIN_LEN, default 1024: flip-flops per chain, equal to shifts per pass (2..2^20).
REQ-003 SHALL have parameter CLK_DIV, default 1: clk cycles per prog_clk phase (1..255).
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins a configuration sequence.
REQ-007 SHALL have port verify_en  input  1: sampled with start; 1 adds a readback pass.
REQ-008 SHALL have port abort  input  1: synchronous cancel of the running sequence.
REQ-009 SHALL have port din  input  NUM_CHAINS: one bit per chain per shift; bit i goes to chain i.
REQ-010 SHALL have port din_valid  input  1: din is valid.
REQ-011 SHALL have port din_ready  output  1: din is accepted on a cycle where din_valid and din_ready are both 1.
REQ-012 SHALL have port prog_clk  output  1: configuration shift clock.
REQ-013 SHALL have port ccff_head  output  NUM_CHAINS: serial data to each chain head.
REQ-014 SHALL have port ccff_tail  input  NUM_CHAINS: serial data from each chain tail.
REQ-015 SHALL have port busy  output  1: sequence in progress.
REQ-016 SHALL have port bitstream_complt  output  1: level, set when a sequence finishes without error.
REQ-017 SHALL have port verify_err  output  1: level, set when a readback mismatch has occurred.
REQ-018 SHALL have port bit_count  output  $clog2(CHAIN_LEN+1): shifts completed in the current pass.

Function
REQ-019 SHALL use the states IDLE, FETCH, PLO, PHI, DONE and FAIL.
REQ-020 SHALL, in IDLE, on start=1 while abort=0: latch verify_en into mode, clear bitstream_complt, verify_err and bit_count, set pass=0, and go to FETCH.
REQ-021 SHALL drive din_ready=1 only in FETCH; on handshake it registers din onto ccff_head and goes to PLO.
REQ-022 SHALL hold prog_clk=0 for exactly CLK_DIV cycles in PLO, then go to PHI.
REQ-023 SHALL hold prog_clk=1 for exactly CLK_DIV cycles in PHI, and hold ccff_head stable across PLO and PHI.
REQ-024 SHALL, on leaving PHI, increment bit_count; if bit_count reaches CHAIN_LEN the pass ends, otherwise go to FETCH.
REQ-025 SHALL, at pass end with pass=0 and mode=0, go to DONE.
REQ-026 SHALL, at pass end with pass=0 and mode=1, set pass=1, clear bit_count and go to FETCH; in pass 1 the host resends the identical bitstream.
REQ-027 SHALL, in pass 1 on the last PLO cycle, compare ccff_tail with ccff_head; any bit mismatch sets verify_err=1 sticky.
REQ-028 SHALL, at pass end of pass 1, go to FAIL if verify_err=1, else to DONE.
REQ-029 SHALL, in DONE, set bitstream_complt=1 and go to IDLE; bitstream_complt holds until the next accepted start or rst.
REQ-030 SHALL, in FAIL, leave bitstream_complt=0 and go to IDLE; verify_err holds until the next accepted start or rst.
REQ-031 SHALL drive busy=1 in every state except IDLE.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL, on abort while busy=1, go to IDLE next cycle with prog_clk=0, ccff_head=0, bitstream_complt=0, and bit_count held for debug.
REQ-034 SHALL give abort priority over start in the same cycle.
REQ-035 SHALL never generate a prog_clk pulse narrower than CLK_DIV cycles in either phase, including across abort.
REQ-036 SHALL allow din_valid=0 in FETCH (host stall) with prog_clk held 0 and no shift counted.
REQ-037 SHALL make every output a register, with no combinational path from any input to any output.

Reset
REQ-038 SHALL, on rst=1 at a clk edge, set state=IDLE, prog_clk=0, ccff_head=0, din_ready=0, busy=0, bitstream_complt=0, verify_err=0, bit_count=0 and pass=0, overriding all other inputs including mid-shift.

Verification
REQ-039 SHALL cover: NUM_CHAINS=1, CHAIN_LEN=8, CLK_DIV=1, start with verify_en=0, din stream 10110010 always valid, model chain -> 8 prog_clk rising edges, chain holds 10110010, bitstream_complt=1 at 33±2 cycles after start, bit_count=8.
REQ-040 SHALL cover: the same setup with verify_en=1, same stream sent twice, model chain correct -> 16 edges, verify_err=0, bitstream_complt=1.
REQ-041 SHALL cover: verify_en=1 with the model chain tail stuck at 0 -> verify_err=1 at the first 1 bit of pass 1, bitstream_complt=0, busy falls after 16 shifts.
REQ-042 SHALL cover: NUM_CHAINS=4, CLK_DIV=3, din_valid toggling randomly -> each prog_clk phase lasts exactly 3 cycles, 8 edges total, all 4 chains match their streams.
REQ-043 SHALL cover: abort after 3 shifts -> next cycle busy=0, prog_clk=0, bit_count=3; a new start then completes normally.
REQ-044 SHALL cover: rst asserted during PHI -> next cycle prog_clk=0, all outputs at reset values; start during busy produces no effect.

Source files
------------

// File: rtl/fcb_config_loader.sv
// fcb_config_loader: shifts a host bitstream into parallel ccff chains, with an optional readback pass.
module fcb_config_loader #(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               verify_en,
  input  logic                               abort,
  input  logic [NUM_CHAINS-1:0]              din,
  input  logic                               din_valid,
  output logic                               din_ready,
  output logic                               prog_clk,
  output logic [NUM_CHAINS-1:0]              ccff_head,
  input  logic [NUM_CHAINS-1:0]              ccff_tail,
  output logic                               busy,
  output logic                               bitstream_complt,
  output logic                               verify_err,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  typedef enum logic [2:0] {IDLE, FETCH, PLO, PHI, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic mode, mode_n, pass, pass_n, pend, pend_n, complt_n, err_n;
  logic [NUM_CHAINS-1:0] head_n;
  logic [BW-1:0] count_n;
  logic last;
  assign last = cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mode <= 1'b0;
      pass <= 1'b0;
      pend <= 1'b0;
      prog_clk <= 1'b0;
      ccff_head <= '0;
      din_ready <= 1'b0;
      busy <= 1'b0;
      bitstream_complt <= 1'b0;
      verify_err <= 1'b0;
      bit_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mode <= mode_n;
      pass <= pass_n;
      pend <= pend_n;
      prog_clk <= state_n == PHI;
      ccff_head <= head_n;
      din_ready <= state == FETCH && state_n == FETCH;
      busy <= state_n != IDLE;
      bitstream_complt <= complt_n;
      verify_err <= err_n;
      bit_count <= count_n;
    end
  end
  // An abort arriving mid-PHI is deferred to the end of the phase so prog_clk never emits a runt high pulse.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mode_n = mode;
    pass_n = pass;
    pend_n = pend;
    head_n = ccff_head;
    complt_n = bitstream_complt;
    err_n = verify_err;
    count_n = bit_count;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = FETCH;
        mode_n = verify_en;
        pass_n = 1'b0;
        complt_n = 1'b0;
        err_n = 1'b0;
        count_n = '0;
      end
      FETCH: if (abort) begin
        state_n = IDLE;
        head_n = '0;
      end else if (din_ready && din_valid) begin
        state_n = PLO;
        head_n = din;
        cnt_n = '0;
      end
      PLO: if (abort) begin
        state_n = IDLE;
        head_n = '0;
      end else if (last) begin
        state_n = PHI;
        cnt_n = '0;
        err_n = verify_err | (pass && ccff_tail != ccff_head);
      end else cnt_n = cnt + 8'd1;
      PHI: if (!last) begin
        cnt_n = cnt + 8'd1;
        pend_n = pend | abort;
      end else if (abort || pend) begin
        state_n = IDLE;
        head_n = '0;
        pend_n = 1'b0;
      end else if (bit_count != BW'(CHAIN_LEN - 1)) begin
        state_n = FETCH;
        count_n = bit_count + BW'(1);
      end else if (mode && !pass) begin
        state_n = FETCH;
        pass_n = 1'b1;
        count_n = '0;
      end else begin
        state_n = verify_err ? FAIL : DONE;
        count_n = bit_count + BW'(1);
      end
      DONE: begin
        state_n = IDLE;
        complt_n = !abort;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
